// File: rtl/exe_stage_unit_pkg.sv
// Shared definitions for the execute stage.
// Contents: status register width, default datapath widths, ALU command
// codes, shifter type codes and the NZCV status structure.
package exe_stage_unit_pkg;

  localparam int STATUS_LEN    = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int CMD_W_DEF     = 4;
  localparam int RADDR_W_DEF   = 4;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exec_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/exe_stage_unit_if.sv
// Bundle of the ID/EX fields entering the execute stage, the memory stall,
// and the EX/MEM, branch and status outputs leaving it.
// Modports: slave = execute stage, master = surrounding pipeline / bench.
// Optional macro FORWARDING_EN adds sel_src1, sel_src2, mem_fwd_val, wb_fwd_val.
interface exe_stage_unit_if
  import exe_stage_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int CMD_W   = 4,
  parameter int RADDR_W = 4
);
  logic                  mem_stall;
  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic                  b_in;
  logic                  s_in;
  logic                  imm_in;
  logic [CMD_W-1:0]      exec_cmd_in;
  logic [ADDR_W-1:0]     pc_in;
  logic [DATA_W-1:0]     val_r_n_in;
  logic [DATA_W-1:0]     val_r_m_in;
  logic [11:0]           shift_operand_in;
  logic [23:0]           signed_imm_24_in;
  logic [RADDR_W-1:0]    dest_in;
  logic                  branch_taken;
  logic [ADDR_W-1:0]     branch_addr;
  logic [STATUS_LEN-1:0] status_out;
  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic                  mem_w_en_out;
  logic [DATA_W-1:0]     alu_res_out;
  logic [DATA_W-1:0]     store_val_out;
  logic [RADDR_W-1:0]    dest_out;
`ifdef FORWARDING_EN
  logic [1:0]            sel_src1;
  logic [1:0]            sel_src2;
  logic [DATA_W-1:0]     mem_fwd_val;
  logic [DATA_W-1:0]     wb_fwd_val;

  modport slave (
    input  mem_stall, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
           signed_imm_24_in, dest_in, sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
    output branch_taken, branch_addr, status_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, alu_res_out, store_val_out, dest_out
  );
  modport master (
    output mem_stall, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
           signed_imm_24_in, dest_in, sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
    input  branch_taken, branch_addr, status_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, alu_res_out, store_val_out, dest_out
  );
`else
  modport slave (
    input  mem_stall, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
           signed_imm_24_in, dest_in,
    output branch_taken, branch_addr, status_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, alu_res_out, store_val_out, dest_out
  );
  modport master (
    output mem_stall, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
           exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
           signed_imm_24_in, dest_in,
    input  branch_taken, branch_addr, status_out, wb_en_out, mem_r_en_out,
           mem_w_en_out, alu_res_out, store_val_out, dest_out
  );
`endif
endinterface

// File: rtl/exe_stage_unit_val2_generator.sv
// Second-operand (Val2) generator: combinational shifter / rotator.
// Ports: val_r_m (Rm value), shift_operand (12-bit field), imm (immediate
// form), mem_access (load/store offset form), val2 (resulting operand).
module val2_generator
  import exe_stage_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] val_r_m,
  input  logic [11:0]       shift_operand,
  input  logic              imm,
  input  logic              mem_access,
  output logic [DATA_W-1:0] val2
);

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input logic [4:0] amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] rm_s;
  logic [4:0]               sh_amt;

  assign rm_s   = val_r_m;
  assign sh_amt = shift_operand[11:7];

  always_comb begin
    val2 = '0;
    if (imm) begin
      // 8-bit immediate rotated right by twice the 4-bit rotate field
      val2 = rotr({{(DATA_W-8){1'b0}}, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_access) begin
      val2 = {{(DATA_W-12){1'b0}}, shift_operand};
    end else if (sh_amt == 5'd0) begin
      val2 = val_r_m;
    end else begin
      case (shift_type_e'(shift_operand[6:5]))
        SHIFT_LSL: val2 = val_r_m << sh_amt;
        SHIFT_LSR: val2 = val_r_m >> sh_amt;
        SHIFT_ASR: val2 = rm_s >>> sh_amt;
        default:   val2 = rotr(val_r_m, sh_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: builds Val2, runs the ALU, owns the NZCV status register,
// computes the branch target and holds the EX/MEM latch.
// Ports: clk, rst (synchronous, active-low), bus (exe_stage_unit_if.slave)
// carrying ID/EX fields, mem_stall, branch redirect, status and EX/MEM outputs.
// Optional macro FORWARDING_EN selects Rn/Rm from the memory or write-back
// forwarding values ahead of Val2 generation.
module exe_stage_unit
  import exe_stage_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int CMD_W   = 4,
  parameter int RADDR_W = 4
) (
  input logic             clk,
  input logic             rst,
  exe_stage_unit_if.slave bus
);

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  logic [DATA_W-1:0]  rn;
  logic [DATA_W-1:0]  rm;
  logic [DATA_W-1:0]  val2;
  logic [CMD_W-1:0]   cmd;
  logic [DATA_W:0]    wide;
  logic [DATA_W-1:0]  res;
  nzcv_t              nzcv_next;
  nzcv_t              status_p1;
  logic [DATA_W-1:0]  alu_res_p1;
  logic [DATA_W-1:0]  store_val_p1;
  logic [RADDR_W-1:0] dest_p1;
  logic               wb_en_p1;
  logic               mem_r_en_p1;
  logic               mem_w_en_p1;

  assign cmd = bus.exec_cmd_in;

`ifdef FORWARDING_EN
  always_comb begin
    case (bus.sel_src1)
      2'b01:   rn = bus.mem_fwd_val;
      2'b10:   rn = bus.wb_fwd_val;
      default: rn = bus.val_r_n_in;
    endcase
    case (bus.sel_src2)
      2'b01:   rm = bus.mem_fwd_val;
      2'b10:   rm = bus.wb_fwd_val;
      default: rm = bus.val_r_m_in;
    endcase
  end
`else
  assign rn = bus.val_r_n_in;
  assign rm = bus.val_r_m_in;
`endif

  val2_generator #(.DATA_W(DATA_W)) u_val2 (
    .val_r_m       (rm),
    .shift_operand (bus.shift_operand_in),
    .imm           (bus.imm_in),
    .mem_access    (bus.mem_r_en_in | bus.mem_w_en_in),
    .val2          (val2)
  );

  // Stage 0: ALU on the DATA_W+1 wide path; logic ops keep the old C and V
  always_comb begin
    wide        = '0;
    res         = '0;
    nzcv_next.c = status_p1.c;
    nzcv_next.v = status_p1.v;
    case (cmd)
      EXE_MOV: res = val2;
      EXE_MVN: res = ~val2;
      EXE_ADD: begin
        wide        = {1'b0, rn} + {1'b0, val2};
        res         = wide[DATA_W-1:0];
        nzcv_next.c = wide[DATA_W];
        nzcv_next.v = add_ovf(rn, val2, res);
      end
      EXE_ADC: begin
        wide        = {1'b0, rn} + {1'b0, val2} + {{DATA_W{1'b0}}, status_p1.c};
        res         = wide[DATA_W-1:0];
        nzcv_next.c = wide[DATA_W];
        nzcv_next.v = add_ovf(rn, val2, res);
      end
      EXE_SUB: begin
        wide        = {1'b0, rn} - {1'b0, val2};
        res         = wide[DATA_W-1:0];
        nzcv_next.c = ~wide[DATA_W];
        nzcv_next.v = sub_ovf(rn, val2, res);
      end
      EXE_SBC: begin
        wide        = {1'b0, rn} - {1'b0, val2} - {{DATA_W{1'b0}}, ~status_p1.c};
        res         = wide[DATA_W-1:0];
        nzcv_next.c = ~wide[DATA_W];
        nzcv_next.v = sub_ovf(rn, val2, res);
      end
      EXE_AND: res = rn & val2;
      EXE_ORR: res = rn | val2;
      EXE_EOR: res = rn ^ val2;
      default: res = '0;
    endcase
    nzcv_next.n = res[DATA_W-1];
    nzcv_next.z = (res == '0);
  end

  assign bus.branch_taken = bus.b_in;
  assign bus.branch_addr  = bus.pc_in
                          + {{(ADDR_W-26){bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

  // Stage 1: status register and EX/MEM latch; reset wins over the stall
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_p1 <= '0;
    end else if (!bus.mem_stall && bus.s_in) begin
      status_p1 <= nzcv_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_res_p1   <= '0;
      store_val_p1 <= '0;
      dest_p1      <= '0;
      wb_en_p1     <= 1'b0;
      mem_r_en_p1  <= 1'b0;
      mem_w_en_p1  <= 1'b0;
    end else if (!bus.mem_stall) begin
      alu_res_p1   <= res;
      store_val_p1 <= rm;
      dest_p1      <= bus.dest_in;
      wb_en_p1     <= bus.wb_en_in;
      mem_r_en_p1  <= bus.mem_r_en_in;
      mem_w_en_p1  <= bus.mem_w_en_in;
    end
  end

  assign bus.status_out    = status_p1;
  assign bus.alu_res_out   = alu_res_p1;
  assign bus.store_val_out = store_val_p1;
  assign bus.dest_out      = dest_p1;
  assign bus.wb_en_out     = wb_en_p1;
  assign bus.mem_r_en_out  = mem_r_en_p1;
  assign bus.mem_w_en_out  = mem_w_en_p1;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed bench for exe_stage_unit with an expected-result queue.
module tb_exe_stage_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_unit_if #(.DATA_W(32), .ADDR_W(32), .CMD_W(4), .RADDR_W(4)) bus ();

  exe_stage_unit #(.DATA_W(32), .ADDR_W(32), .CMD_W(4), .RADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] store;
    logic [3:0]  dest;
    logic [3:0]  nzcv;
    logic        wb;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t sbq[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sbq.pop_front();
    chk({tag, ".res"},   bus.alu_res_out,   e.res);
    chk({tag, ".store"}, bus.store_val_out, e.store);
    chk({tag, ".dest"},  {28'd0, bus.dest_out},   {28'd0, e.dest});
    chk({tag, ".nzcv"},  {28'd0, bus.status_out}, {28'd0, e.nzcv});
    chk({tag, ".wb"},    {31'd0, bus.wb_en_out},    {31'd0, e.wb});
    chk({tag, ".mr"},    {31'd0, bus.mem_r_en_out}, {31'd0, e.mr});
    chk({tag, ".mw"},    {31'd0, bus.mem_w_en_out}, {31'd0, e.mw});
  endtask

  // Push the expectation for the inputs currently driven, clock once, compare.
  task automatic step(input string tag, input logic [31:0] res,
                      input logic [31:0] store, input logic [3:0] nzcv);
    exp_t e;
    if (!rst) begin
      e.res = '0; e.store = '0; e.dest = '0; e.nzcv = '0;
      e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    end else if (bus.mem_stall) begin
      e = last;
    end else begin
      e.res = res; e.store = store; e.nzcv = nzcv;
      e.dest = bus.dest_in; e.wb = bus.wb_en_in;
      e.mr = bus.mem_r_en_in; e.mw = bus.mem_w_en_in;
    end
    sbq.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic imm, input logic [11:0] sh, input logic s);
    bus.exec_cmd_in      = cmd;
    bus.val_r_n_in       = rn;
    bus.val_r_m_in       = rm;
    bus.imm_in           = imm;
    bus.shift_operand_in = sh;
    bus.s_in             = s;
  endtask

  initial begin
    rst                  = 1'b0;
    bus.mem_stall        = 1'b0;
    bus.wb_en_in         = 1'b1;
    bus.mem_r_en_in      = 1'b1;
    bus.mem_w_en_in      = 1'b1;
    bus.b_in             = 1'b0;
    bus.pc_in            = 32'h200;
    bus.signed_imm_24_in = 24'h000001;
    bus.dest_in          = 4'hA;
`ifdef FORWARDING_EN
    bus.sel_src1    = 2'b00;
    bus.sel_src2    = 2'b00;
    bus.mem_fwd_val = 32'h0;
    bus.wb_fwd_val  = 32'h0;
`endif
    set_op(4'b0010, 32'h1234, 32'h5678, 1'b1, 12'h0FF, 1'b1);

    // Reset with nonzero inputs for two cycles
    step("rst0", 32'h0, 32'h0, 4'h0);
    step("rst1", 32'h0, 32'h0, 4'h0);

    rst = 1'b1;
    bus.mem_r_en_in = 1'b0;
    bus.mem_w_en_in = 1'b0;
    bus.dest_in     = 4'h3;
    set_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_AAAA, 1'b1, 12'h001, 1'b1);
    #1;
    chk("br_not_taken", {31'd0, bus.branch_taken}, 32'd0);
    chk("br_addr_pos",  bus.branch_addr, 32'h204);
    step("add_ovf", 32'h8000_0000, 32'h0000_AAAA, 4'b1001);

    set_op(4'b0100, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1);
    step("cmp_eq", 32'h0, 32'd5, 4'b0110);

    set_op(4'b0011, 32'd1, 32'd0, 1'b1, 12'h001, 1'b1);
    step("adc_c", 32'd3, 32'd0, 4'b0000);

    set_op(4'b0001, 32'd0, 32'd0, 1'b1, 12'h4FF, 1'b0);
    step("mov_imm_rot", 32'hFF00_0000, 32'd0, 4'b0000);

    set_op(4'b0001, 32'd0, 32'h8000_0000, 1'b0, 12'h240, 1'b1);
    step("mov_asr4", 32'hF800_0000, 32'h8000_0000, 4'b1000);

    set_op(4'b0001, 32'd0, 32'h0000_00AB, 1'b0, 12'h460, 1'b0);
    step("mov_ror8", 32'hAB00_0000, 32'h0000_00AB, 4'b1000);

    set_op(4'b0100, 32'd0, 32'd0, 1'b1, 12'h001, 1'b1);
    step("sub_borrow", 32'hFFFF_FFFF, 32'd0, 4'b1000);

    set_op(4'b0101, 32'd5, 32'd0, 1'b1, 12'h002, 1'b1);
    step("sbc_nc", 32'd2, 32'd0, 4'b0010);

    bus.mem_r_en_in = 1'b1;
    bus.dest_in     = 4'h7;
    set_op(4'b0010, 32'h1000, 32'h1234, 1'b0, 12'hFFF, 1'b0);
    step("ldr_addr", 32'h1FFF, 32'h1234, 4'b0010);

    // Stall: inputs keep changing with s_in=1, everything must hold
    bus.mem_stall   = 1'b1;
    bus.mem_r_en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.dest_in = 4'(i + 1);
      set_op(4'b0100, 32'(i), 32'hFFFF_0000, 1'b1, 12'h001, 1'b1);
      step("stall", 32'h0, 32'h0, 4'h0);
    end

    bus.mem_stall = 1'b0;
    bus.dest_in   = 4'h9;
    set_op(4'b1000, 32'h0000_F0F0, 32'h0000_FFFF, 1'b0, 12'h000, 1'b1);
    step("eor_resume", 32'h0000_0F0F, 32'h0000_FFFF, 4'b0010);

    bus.wb_en_in    = 1'b0;
    bus.mem_w_en_in = 1'b1;
    set_op(4'b0010, 32'h2000, 32'hDEAD_BEEF, 1'b0, 12'h004, 1'b0);
    step("str_addr", 32'h2004, 32'hDEAD_BEEF, 4'b0010);

    bus.mem_w_en_in      = 1'b0;
    bus.b_in             = 1'b1;
    bus.pc_in            = 32'h100;
    bus.signed_imm_24_in = 24'hFFFFFE;
    set_op(4'b0000, 32'h55, 32'h66, 1'b0, 12'h000, 1'b0);
    #1;
    chk("br_taken",    {31'd0, bus.branch_taken}, 32'd1);
    chk("br_addr_neg", bus.branch_addr, 32'h0000_00F8);
    step("branch_latch", 32'h0, 32'h66, 4'b0010);

    // Reset wins over a simultaneous stall
    bus.b_in      = 1'b0;
    bus.mem_stall = 1'b1;
    rst           = 1'b0;
    step("rst_over_stall", 32'h0, 32'h0, 4'h0);
    bus.mem_stall = 1'b0;
    rst           = 1'b1;

`ifdef FORWARDING_EN
    bus.wb_en_in    = 1'b1;
    bus.sel_src1    = 2'b01;
    bus.sel_src2    = 2'b10;
    bus.mem_fwd_val = 32'h10;
    bus.wb_fwd_val  = 32'h55;
    set_op(4'b0010, 32'h999, 32'h77, 1'b1, 12'h001, 1'b0);
    step("fwd", 32'h11, 32'h55, 4'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
